// File: rtl/seq_divider.sv
// Purpose: iterative restoring divider for RV32M DIV/DIVU/REM/REMU. It produces one quotient bit per clock.
// Latency: n+1 cycles from start to done in the normal case; 1 cycle for divide-by-zero and signed overflow.
// Backpressure: a start while busy is dropped; the EX stage stalls on busy, and results hold until the next done.
//
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   start, is_signed            request and signedness, sampled only while busy=0
//   dividend, divisor           operands, sampled with start
//   busy, done                  busy is high in CALC and DONE; done pulses for one cycle with the results
//   quotient, remainder         results, registered and held until the next done

// Ripple-carry adder shared with the ALU datapath.
module rca #(
    parameter int n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         c_in,
    output logic [n-1:0] sum,
    output logic         c_out
);
    logic [n:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < n; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[n];
endmodule

module seq_divider #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder
);
    localparam int          CW      = $clog2(n + 1);
    localparam logic [n-1:0] ONE    = {{(n-1){1'b0}}, 1'b1};
    localparam logic [n-1:0] ONES   = {n{1'b1}};
    localparam logic [n-1:0] INT_MIN = {1'b1, {(n-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [n-1:0]  a_reg;     // working dividend; quotient bits shift in at the LSB
    logic [n-1:0]  b_reg;     // working divisor (magnitude)
    logic [n:0]    p_reg;     // partial remainder
    logic          neg_q;
    logic          neg_r;

    // Operand magnitudes. For the most negative value the negation wraps back to 2^(n-1),
    // which is the correct magnitude when it is read as unsigned.
    logic [n-1:0] abs_a;
    logic [n-1:0] abs_b;
    logic         div_zero;
    logic         sgn_ovf;

    assign abs_a    = (is_signed && dividend[n-1]) ? (~dividend + ONE) : dividend;
    assign abs_b    = (is_signed && divisor[n-1])  ? (~divisor + ONE)  : divisor;
    assign div_zero = (divisor == '0);
    assign sgn_ovf  = is_signed && (dividend == INT_MIN) && (divisor == ONES);

    // One restoring step: shift {P, A} left, then try P - B.
    logic [n:0] shifted;
    logic [n:0] b_inv;
    logic [n:0] trial;
    logic       trial_cout_unused;
    logic       trial_ok;

    assign shifted = {p_reg[n-1:0], a_reg[n-1]};
    assign b_inv   = ~{1'b0, b_reg};

    rca #(.n(n + 1)) u_sub (
        .a     (shifted),
        .b     (b_inv),
        .c_in  (1'b1),
        .sum   (trial),
        .c_out (trial_cout_unused)
    );

    // P < B always holds before the shift, so a non-negative trial means shifted >= B.
    assign trial_ok = ~trial[n];

    logic [n-1:0] q_step;
    logic [n-1:0] r_step;
    logic [n-1:0] q_fix;
    logic [n-1:0] r_fix;

    assign q_step = {a_reg[n-2:0], trial_ok};
    assign r_step = trial_ok ? trial[n-1:0] : shifted[n-1:0];
    assign q_fix  = neg_q ? (~q_step + ONE) : q_step;
    assign r_fix  = neg_r ? (~r_step + ONE) : r_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        a_reg <= abs_a;
                        b_reg <= abs_b;
                        p_reg <= '0;
                        cnt   <= CW'(n);
                        neg_q <= is_signed & (dividend[n-1] ^ divisor[n-1]);
                        neg_r <= is_signed & dividend[n-1];
                        if (div_zero) begin
                            quotient  <= ONES;
                            remainder <= dividend;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (sgn_ovf) begin
                            quotient  <= dividend;
                            remainder <= '0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    a_reg <= q_step;
                    p_reg <= trial_ok ? trial : shifted;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Purpose: scoreboard bench for seq_divider. It issues directed and random divisions and compares each done against a reference model.
// Latency: every expected result carries the cycle in which its done must appear.
// Backpressure: new work is issued only while busy=0, except for deliberate starts that the divider must ignore.
module tb_seq_divider;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;

    seq_divider #(.n(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   last_start = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference model taken directly from the RISC-V M-extension rules.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         output logic [N-1:0] q, output logic [N-1:0] r, output int lat);
        logic signed [N-1:0] sa;
        logic signed [N-1:0] sb_;
        sa  = a;
        sb_ = b;
        lat = N + 1;
        if (b == 0) begin
            q = '1; r = a; lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 0; lat = 1;
        end else if (s) begin
            q = sa / sb_;
            r = sa % sb_;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input bit expect_it);
        int   guard;
        exp_t e;
        int   lat;
        guard = 0;
        @(negedge clk);
        while (busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL issue_wait: busy stuck at %b expected 0", busy);
        end
        dividend   = a;
        divisor    = b;
        is_signed  = s;
        start      = 1'b1;
        last_start = cyc;
        if (expect_it) begin
            model(a, b, s, e.q, e.r, lat);
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no request pending (q=%h r=%h)", quotient, remainder);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at cycle %0d, expected to finish", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        int g;
        int s1;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        rst_n = 1'b1;

        // Unsigned 100/7, plus the busy window.
        issue(100, 7, 0, 1);
        bc = (busy === 1'b1) ? 1 : 0;
        g  = 0;
        while (g < 100) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            bc++;
            g++;
        end
        chk("busy_cycles", bc, 33);

        // Signed cases and the special cases.
        issue(-7, 2, 1, 1);
        issue(7, -2, 1, 1);
        issue(32'h1234_5678, 0, 1, 1);
        issue(32'h1234_5678, 0, 0, 1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1, 1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 0, 1);

        // Back-to-back issue: the second start lands in the cycle after done.
        issue(1000, 33, 0, 1);
        s1 = last_start;
        issue(-1000, 33, 1, 1);
        chk("restart_gap", last_start - s1, N + 2);

        // A start in cycle 10 of an operation must be ignored.
        issue(32'hCAFE_BABE, 13, 0, 1);
        while (cyc < last_start + 10) @(negedge clk);
        chk("busy_mid", {31'b0, busy}, 1);
        dividend = 5; divisor = 1; is_signed = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // A reset in cycle 15 aborts the operation without a done.
        issue(32'h0DEA_DBEE, 3, 0, 0);
        while (cyc < last_start + 15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_done", {31'b0, done}, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        repeat (40) @(negedge clk);
        issue(32'hFFFF_FFFF, 1, 0, 1);

        // Random operands, with divisors biased toward edge values.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 255);
                2: rb = -$urandom_range(1, 16);
                3: rb = 0;
                default: rb = 32'hFFFF_FFFF;
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)), 1);
        end

        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
